uart_loader: RTL and testbench



---
 rtl/uart_loader_if.sv | 28 ++
 rtl/uart_loader.sv | 143 ++++++++++++++
 tb/tb_uart_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_if.sv
// UART receive/transmit handshake and program-memory write port
// seen by the serial program loader.
interface uart_loader_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [7:0]            rx_data;
    logic                  rx_full;
    logic                  rx_rd;
    logic [7:0]            tx_data;
    logic                  tx_wr;
    logic                  tx_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr;
    logic                  mem_byt;
    logic [15:0]           mem_wr_data;

    modport master (
        input  rx_data, rx_full, tx_ready,
        output rx_rd, tx_data, tx_wr,
        output mem_addr, mem_wr, mem_byt, mem_wr_data
    );

    modport slave (
        output rx_data, rx_full, tx_ready,
        input  rx_rd, tx_data, tx_wr,
        input  mem_addr, mem_wr, mem_byt, mem_wr_data
    );
endinterface

// File: rtl/uart_loader.sv
// Serial program loader: parses SYNC/count/data/checksum frames,
// writes 16-bit words to program memory and replies ACK or NAK.
module uart_loader #(
    parameter int                    ADDR_WIDTH     = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h4000,
    parameter int                    TIMEOUT_CYCLES = 100000
) (
    input  logic          clk,
    input  logic          rst,
    uart_loader_if.master bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          err,
    output logic [15:0]   words_loaded
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, CSUM, REPLY
    } state_t;

    state_t        state, state_n;
    logic [15:0]   cnt;
    logic [7:0]    hi;
    logic [7:0]    sum;
    logic [TW-1:0] tcnt;
    logic          wr_pend;
    logic          in_frame, take, tmo, fire, sum_ok;

    assign bus.mem_byt = 1'b0;
    assign busy        = (state != IDLE);

    always_comb begin
        state_n  = state;
        in_frame = (state != IDLE) && (state != REPLY);
        tmo      = in_frame && (tcnt == TW'(TIMEOUT_CYCLES));
        // rx_rd high means the UART is still clearing rx_full
        take     = bus.rx_full && !bus.rx_rd &&
                   (state != REPLY) && !tmo;
        fire     = (state == REPLY) && bus.tx_ready;
        sum_ok   = (sum == 8'h00);
        unique case (state)
            IDLE:
                if (take && bus.rx_data == SYNC) state_n = CNT_HI;
            CNT_HI:
                if (take) state_n = CNT_LO;
            CNT_LO:
                if (take)
                    state_n = ({cnt[15:8], bus.rx_data} == 16'd0)
                              ? CSUM : DAT_HI;
            DAT_HI:
                if (take) state_n = DAT_LO;
            DAT_LO:
                if (take)
                    state_n = (words_loaded + 16'd1 == cnt)
                              ? CSUM : DAT_HI;
            CSUM:
                if (take) state_n = REPLY;
            REPLY:
                if (fire) state_n = IDLE;
            default:
                state_n = IDLE;
        endcase
        if (tmo) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rx_rd       <= 1'b0;
            bus.tx_data     <= 8'h00;
            bus.tx_wr       <= 1'b0;
            bus.mem_addr    <= BASE_ADDR;
            bus.mem_wr      <= 1'b0;
            bus.mem_wr_data <= 16'h0000;
            cpu_hold        <= 1'b1;
            err             <= 1'b0;
            words_loaded    <= 16'd0;
            cnt             <= 16'd0;
            hi              <= 8'h00;
            sum             <= 8'h00;
            tcnt            <= '0;
            wr_pend         <= 1'b0;
        end else begin
            bus.rx_rd  <= take;
            bus.tx_wr  <= fire;
            bus.mem_wr <= wr_pend;
            wr_pend    <= 1'b0;
            if (take || !in_frame || tmo) tcnt <= '0;
            else                          tcnt <= tcnt + TW'(1);
            // Address advances once the strobe for it has been issued
            if (bus.mem_wr) begin
                bus.mem_addr <= bus.mem_addr + ADDR_WIDTH'(2);
                words_loaded <= words_loaded + 16'd1;
            end
            if (take) begin
                unique case (state)
                    IDLE:
                        if (bus.rx_data == SYNC) begin
                            cpu_hold     <= 1'b1;
                            err          <= 1'b0;
                            words_loaded <= 16'd0;
                            sum          <= 8'h00;
                            bus.mem_addr <= BASE_ADDR;
                        end
                    CNT_HI: begin
                        cnt[15:8] <= bus.rx_data;
                        sum       <= sum + bus.rx_data;
                    end
                    CNT_LO: begin
                        cnt[7:0] <= bus.rx_data;
                        sum      <= sum + bus.rx_data;
                    end
                    DAT_HI: begin
                        hi  <= bus.rx_data;
                        sum <= sum + bus.rx_data;
                    end
                    DAT_LO: begin
                        bus.mem_wr_data <= {hi, bus.rx_data};
                        wr_pend         <= 1'b1;
                        sum             <= sum + bus.rx_data;
                    end
                    CSUM:
                        sum <= sum + bus.rx_data;
                    default: ;
                endcase
            end
            if (fire) begin
                bus.tx_data <= sum_ok ? ACK : NAK;
                if (sum_ok) cpu_hold <= 1'b0;
                else        err      <= 1'b1;
            end
            if (tmo) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_loader.sv
// Randomized frame bench for uart_loader with a frame-level
// reference model, a paced UART byte source and write/reply monitors.
module tb_uart_loader;
    localparam int          TMO  = 300;
    localparam logic [15:0] BASE = 16'h4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_hold, busy, err;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    uart_loader_if #(.ADDR_WIDTH(16)) bus ();

    uart_loader #(
        .ADDR_WIDTH    (16),
        .BASE_ADDR     (BASE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .err         (err),
        .words_loaded(words_loaded)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART receive side: one byte presented at a time, random gaps
    logic [7:0] rxq[$];
    int         gap;

    initial begin
        bus.rx_full = 1'b0;
        bus.rx_data = 8'h00;
        gap = 0;
        forever begin
            @(negedge clk);
            if (bus.rx_rd && rxq.size() > 0) begin
                void'(rxq.pop_front());
                gap = $urandom_range(0, 3);
            end
            if (gap > 0) begin
                gap--;
                bus.rx_full = 1'b0;
            end else if (rxq.size() > 0) begin
                bus.rx_full = 1'b1;
                bus.rx_data = rxq[0];
            end else begin
                bus.rx_full = 1'b0;
            end
        end
    end

    logic [15:0] w_addr[$];
    logic [15:0] w_data[$];
    logic [7:0]  tx_seen[$];
    int          byt_bad;

    initial begin
        byt_bad = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_wr) begin
                w_addr.push_back(bus.mem_addr);
                w_data.push_back(bus.mem_wr_data);
                if (bus.mem_byt) byt_bad++;
            end
            if (bus.tx_wr) tx_seen.push_back(bus.tx_data);
        end
    end

    logic [15:0] e_addr[$];
    logic [15:0] e_data[$];
    logic [7:0]  e_tx;
    logic        e_err, e_hold;
    logic [15:0] e_words;

    task automatic clr();
        w_addr.delete();
        w_data.delete();
        tx_seen.delete();
        byt_bad = 0;
    endtask

    // Frame-level expectation: skip to SYNC, then count/words/checksum
    task automatic model(input logic [7:0] fr[$]);
        int          i;
        int          n;
        logic [7:0]  s;
        logic [15:0] a;
        e_addr.delete();
        e_data.delete();
        i = 0;
        while (i < fr.size() && fr[i] != 8'hA5) i++;
        i++;
        n = {fr[i], fr[i+1]};
        s = fr[i] + fr[i+1];
        a = BASE;
        for (int k = 0; k < n; k++) begin
            e_addr.push_back(a);
            e_data.push_back({fr[i+2+2*k], fr[i+3+2*k]});
            s = s + fr[i+2+2*k] + fr[i+3+2*k];
            a = a + 16'd2;
        end
        s = s + fr[i+2+2*n];
        e_tx    = (s == 8'h00) ? 8'h06 : 8'h15;
        e_err   = (s != 8'h00);
        e_hold  = (s != 8'h00);
        e_words = 16'(n);
    endtask

    task automatic make_frame(input int n, input bit good,
                              input int junk, output logic [7:0] fr[$]);
        logic [7:0] s;
        logic [7:0] b;
        fr.delete();
        for (int j = 0; j < junk; j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            fr.push_back(b);
        end
        fr.push_back(8'hA5);
        fr.push_back(8'(n >> 8));
        fr.push_back(8'(n));
        s = 8'(n >> 8) + 8'(n);
        for (int j = 0; j < 2 * n; j++) begin
            b = 8'($urandom_range(0, 255));
            fr.push_back(b);
            s = s + b;
        end
        if (good) fr.push_back(8'h00 - s);
        else      fr.push_back(8'h00 - s + 8'($urandom_range(1, 255)));
    endtask

    task automatic wait_done(input string tag);
        for (int c = 0; c < 4000 && rxq.size() != 0; c++) @(negedge clk);
        check({tag, ".drain"}, rxq.size(), 0);
        for (int c = 0; c < 4 * TMO && busy; c++) @(negedge clk);
        check({tag, ".idle"}, busy, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic compare(input string tag);
        check({tag, ".nwr"}, w_addr.size(), e_addr.size());
        for (int i = 0; i < w_addr.size() && i < e_addr.size(); i++) begin
            check({tag, ".addr"}, w_addr[i], e_addr[i]);
            check({tag, ".data"}, w_data[i], e_data[i]);
        end
        check({tag, ".ntx"}, tx_seen.size(), 1);
        if (tx_seen.size() > 0) check({tag, ".tx"}, tx_seen[0], e_tx);
        check({tag, ".err"}, err, e_err);
        check({tag, ".hold"}, cpu_hold, e_hold);
        check({tag, ".words"}, words_loaded, e_words);
        check({tag, ".byt"}, byt_bad, 0);
    endtask

    task automatic run_frame(input logic [7:0] fr[$], input string tag);
        clr();
        model(fr);
        foreach (fr[i]) rxq.push_back(fr[i]);
        wait_done(tag);
        compare(tag);
    endtask

    logic [7:0] fr[$];

    initial begin
        rst = 1'b1;
        bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.hold", cpu_hold, 1);
        check("rst.busy", busy, 0);
        check("rst.err", err, 0);
        check("rst.words", words_loaded, 0);
        check("rst.addr", bus.mem_addr, BASE);
        check("rst.strobes", {bus.mem_wr, bus.tx_wr, bus.rx_rd}, 0);
        check("rst.txd", bus.tx_data, 0);
        check("rst.wdata", bus.mem_wr_data, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        run_frame(fr, "ack2");
        fr[7] = 8'h41;
        run_frame(fr, "nak2");
        fr = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame(fr, "junk0");

        // Abandoned frame: hi byte of first word only
        clr();
        fr = '{8'hA5, 8'h00, 8'h01, 8'h12};
        foreach (fr[i]) rxq.push_back(fr[i]);
        for (int c = 0; c < 100 && rxq.size() != 0; c++) @(negedge clk);
        repeat (TMO / 2) @(negedge clk);
        check("tmo.busy_mid", busy, 1);
        repeat (TMO) @(negedge clk);
        check("tmo.busy", busy, 0);
        check("tmo.err", err, 1);
        check("tmo.hold", cpu_hold, 1);
        check("tmo.nwr", w_addr.size(), 0);
        check("tmo.ntx", tx_seen.size(), 0);
        make_frame(1, 1'b1, 0, fr);
        run_frame(fr, "tmo.next");

        // Transmitter stalled during the reply
        clr();
        make_frame(2, 1'b1, 0, fr);
        model(fr);
        bus.tx_ready = 1'b0;
        foreach (fr[i]) rxq.push_back(fr[i]);
        for (int c = 0; c < 200 && rxq.size() != 0; c++) @(negedge clk);
        repeat (50) @(negedge clk);
        check("stall.busy", busy, 1);
        check("stall.ntx", tx_seen.size(), 0);
        bus.tx_ready = 1'b1;
        wait_done("stall");
        compare("stall");

        // Reset in the middle of a frame
        clr();
        fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
        foreach (fr[i]) rxq.push_back(fr[i]);
        for (int c = 0; c < 100 && rxq.size() != 0; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("mid.nwr", w_addr.size(), 1);
        rst = 1'b1;
        rxq.delete();
        #1;
        check("mid.hold", cpu_hold, 1);
        check("mid.busy", busy, 0);
        check("mid.addr", bus.mem_addr, BASE);
        check("mid.words", words_loaded, 0);
        clr();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mid.post_wr", w_addr.size(), 0);
        check("mid.post_tx", tx_seen.size(), 0);
        make_frame(2, 1'b1, 0, fr);
        run_frame(fr, "mid.fresh");

        for (int t = 0; t < 15; t++) begin
            make_frame($urandom_range(0, 6), $urandom_range(0, 3) != 0,
                       $urandom_range(0, 2), fr);
            run_frame(fr, $sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
